paddle_color_calib_ctrl: RTL and testbench

Sequencer sitting in front of the paddle localization datapath. It qualifies incoming pixels into the img_in_valid and frameCode strobes consumed by the two-colour mask and the denoise sliding window. It also runs a calibration FSM that, on request, averages U/V over a fixed square box at screen centre for one frame and loads the result into the uTarget/vTarget registers for colour 1 or colour 2.

---
 rtl/paddle_color_calib_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_paddle_color_calib_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/paddle_color_calib_ctrl.sv
// Pixel qualifier and U/V calibration sequencer for the paddle localization datapath.
// Produces img_in_valid/frameCode strobes and loads colour targets from a screen-centre box average.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | no calibration; waits for a cal_req pulse
// S_ARM   | colour latched; waits for the next frame start
// S_ACCUM | summing U/V over the calibration box
// S_WRITE | loads the averaged targets and raises cal_done
module paddle_color_calib_ctrl #(
    parameter int THRESH_WIDTH = 6,
    parameter int ACTIVE_ROWS  = 480,
    parameter int ACTIVE_COLS  = 640,
    parameter int BOX_LOG2     = 3,
    parameter int BOX_ROW0     = 236,
    parameter int BOX_COL0     = 316,
    parameter logic [THRESH_WIDTH-1:0] U1_DEFAULT = '0,
    parameter logic [THRESH_WIDTH-1:0] V1_DEFAULT = '0,
    parameter logic [THRESH_WIDTH-1:0] U2_DEFAULT = '0,
    parameter logic [THRESH_WIDTH-1:0] V2_DEFAULT = '0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    pix_valid,
    input  logic [10:0]             row,
    input  logic [11:0]             col,
    input  logic [8:0]              U,
    input  logic [8:0]              V,
    input  logic [1:0]              cal_req,
    output logic                    img_in_valid,
    output logic                    frameCode,
    output logic [THRESH_WIDTH-1:0] uTarget1,
    output logic [THRESH_WIDTH-1:0] vTarget1,
    output logic [THRESH_WIDTH-1:0] uTarget2,
    output logic [THRESH_WIDTH-1:0] vTarget2,
    output logic                    busy,
    output logic                    cal_done
);

    localparam int SW = 9 + 2 * BOX_LOG2;
    localparam int CW = 2 * BOX_LOG2 + 1;
    localparam int NS = 2 ** (2 * BOX_LOG2);
    localparam int BOX_SIDE = 2 ** BOX_LOG2;

    localparam logic [10:0] ROWS_L     = 11'(ACTIVE_ROWS);
    localparam logic [11:0] COLS_L     = 12'(ACTIVE_COLS);
    localparam logic [10:0] BOX_R_LO   = 11'(BOX_ROW0);
    localparam logic [10:0] BOX_R_HI   = 11'(BOX_ROW0 + BOX_SIDE - 1);
    localparam logic [11:0] BOX_C_LO   = 12'(BOX_COL0);
    localparam logic [11:0] BOX_C_HI   = 12'(BOX_COL0 + BOX_SIDE - 1);
    localparam logic [CW-1:0] NS_L     = CW'(NS);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_ACCUM, S_WRITE} state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                    r_img_in_valid;
    logic                    r_frame_code;
    logic                    r_cal_done;
    logic                    r_sel;
    logic signed [SW-1:0]    r_sum_u;
    logic signed [SW-1:0]    r_sum_v;
    logic [CW-1:0]           r_cnt;
    logic [THRESH_WIDTH-1:0] r_u1, r_v1, r_u2, r_v2;

    logic                    w_active;
    logic                    w_frame_start;
    logic                    w_in_box;
    logic                    w_clr;
    logic                    w_load;
    logic                    w_acc;
    logic                    w_wr;
    logic                    w_busy;
    logic [CW-1:0]           w_cnt_nxt;
    logic signed [SW-1:0]    w_u_ext;
    logic signed [SW-1:0]    w_v_ext;

    assign w_active      = pix_valid && (row < ROWS_L) && (col < COLS_L);
    assign w_frame_start = pix_valid && (row == 11'd0) && (col == 12'd0);
    assign w_in_box      = pix_valid && (row >= BOX_R_LO) && (row <= BOX_R_HI)
                                     && (col >= BOX_C_LO) && (col <= BOX_C_HI);

    assign w_u_ext = {{(SW-9){U[8]}}, U};
    assign w_v_ext = {{(SW-9){V[8]}}, V};

    // Sample count as it will stand after this cycle; a frame start reloads it.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_load) begin
            w_cnt_nxt = w_in_box ? ONE_CNT : '0;
        end else if (w_acc) begin
            w_cnt_nxt = r_cnt + ONE_CNT;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (cal_req != 2'b00) begin
                    w_state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                if (w_frame_start) begin
                    w_state_nxt = (w_cnt_nxt == NS_L) ? S_WRITE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if ((w_load || w_acc) && (w_cnt_nxt == NS_L)) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_clr  = 1'b0;
        w_load = 1'b0;
        w_acc  = 1'b0;
        w_wr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_clr = (cal_req != 2'b00);
            end
            S_ARM: begin
                w_busy = 1'b1;
                w_load = w_frame_start;
            end
            S_ACCUM: begin
                w_busy = 1'b1;
                w_load = w_frame_start;
                w_acc  = w_in_box && !w_frame_start;
            end
            S_WRITE: begin
                w_busy = 1'b1;
                w_wr   = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_img_in_valid <= 1'b0;
            r_frame_code   <= 1'b0;
        end else begin
            r_img_in_valid <= w_active;
            r_frame_code   <= r_frame_code ^ w_frame_start;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sel   <= 1'b0;
            r_sum_u <= '0;
            r_sum_v <= '0;
            r_cnt   <= '0;
        end else if (w_clr) begin
            r_sel   <= ~cal_req[0];
            r_sum_u <= '0;
            r_sum_v <= '0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_sum_u <= w_in_box ? w_u_ext : '0;
            r_sum_v <= w_in_box ? w_v_ext : '0;
            r_cnt   <= w_cnt_nxt;
        end else if (w_acc) begin
            r_sum_u <= r_sum_u + w_u_ext;
            r_sum_v <= r_sum_v + w_v_ext;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The sum cannot overflow, so the top bits of the sum are exactly the top bits of the 9-bit average.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_u1       <= U1_DEFAULT;
            r_v1       <= V1_DEFAULT;
            r_u2       <= U2_DEFAULT;
            r_v2       <= V2_DEFAULT;
            r_cal_done <= 1'b0;
        end else begin
            r_cal_done <= w_wr;
            if (w_wr && !r_sel) begin
                r_u1 <= r_sum_u[SW-1 -: THRESH_WIDTH];
                r_v1 <= r_sum_v[SW-1 -: THRESH_WIDTH];
            end
            if (w_wr && r_sel) begin
                r_u2 <= r_sum_u[SW-1 -: THRESH_WIDTH];
                r_v2 <= r_sum_v[SW-1 -: THRESH_WIDTH];
            end
        end
    end

    assign img_in_valid = r_img_in_valid;
    assign frameCode    = r_frame_code;
    assign uTarget1     = r_u1;
    assign vTarget1     = r_v1;
    assign uTarget2     = r_u2;
    assign vTarget2     = r_v2;
    assign busy         = w_busy;
    assign cal_done     = r_cal_done;

endmodule

// File: tb/tb_paddle_color_calib_ctrl.sv
// Scoreboard bench for paddle_color_calib_ctrl: random sparse frames checked against a
// sample-list reference model of the pixel strobes and the box-average calibration.
module tb_paddle_color_calib_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        pix_valid = 1'b0;
    logic [10:0] row = '0;
    logic [11:0] col = '0;
    logic [8:0]  U = '0;
    logic [8:0]  V = '0;
    logic [1:0]  cal_req = '0;
    logic        img_in_valid, frameCode, busy, cal_done;
    logic [5:0]  uTarget1, vTarget1, uTarget2, vTarget2;

    paddle_color_calib_ctrl dut (
        .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid), .row(row), .col(col),
        .U(U), .V(V), .cal_req(cal_req), .img_in_valid(img_in_valid), .frameCode(frameCode),
        .uTarget1(uTarget1), .vTarget1(vTarget1), .uTarget2(uTarget2), .vTarget2(vTarget2),
        .busy(busy), .cal_done(cal_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct { bit iv; bit fc; bit bsy; bit done; } pix_exp_t;
    typedef struct { int t[4]; } cal_exp_t;
    pix_exp_t pq[$];
    cal_exp_t cq[$];

    // Reference model: 0 idle, 1 waiting for frame, 2 collecting, 3 writing.
    int m_phase = 0;
    bit m_fc = 0;
    int m_sel = 0;
    int m_su[$];
    int m_sv[$];
    int m_t[4] = '{0, 0, 0, 0};
    int g_cu = 0, g_cv = 0;

    function automatic int fdiv(int a, int b);
        int q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic int target_of(int samples[$]);
        int s = 0;
        int avg;
        foreach (samples[i]) s += samples[i];
        avg = fdiv(s, samples.size());
        return fdiv(avg, 8) & 63;
    endfunction

    function automatic bit in_box(bit v, int r, int c);
        return v && r >= 236 && r <= 243 && c >= 316 && c <= 323;
    endfunction

    task automatic model_step(bit v, int r, int c, int u, int vv, bit [1:0] req);
        pix_exp_t e;
        cal_exp_t ce;
        bit fs = v && r == 0 && c == 0;
        e.iv = v && r < 480 && c < 640;
        if (fs) m_fc = ~m_fc;
        e.fc = m_fc;
        e.done = (m_phase == 3);
        case (m_phase)
            0: if (req != 2'b00) begin m_sel = req[0] ? 0 : 1; m_phase = 1; end
            1, 2: begin
                if (fs) begin m_phase = 2; m_su.delete(); m_sv.delete(); end
                if (m_phase == 2 && in_box(v, r, c)) begin
                    m_su.push_back(u);
                    m_sv.push_back(vv);
                    if (m_su.size() == 64) begin
                        m_t[2*m_sel]   = target_of(m_su);
                        m_t[2*m_sel+1] = target_of(m_sv);
                        ce.t = m_t;
                        cq.push_back(ce);
                        m_phase = 3;
                    end
                end
            end
            default: m_phase = 0;
        endcase
        e.bsy = (m_phase != 0);
        pq.push_back(e);
    endtask

    task automatic drive(bit v, int r, int c, int u, int vv, bit [1:0] req);
        @(posedge clk);
        #1;
        pix_valid = v;
        row = r[10:0];
        col = c[11:0];
        U = u[8:0];
        V = vv[8:0];
        cal_req = req;
        model_step(v, r, c, u, vv, req);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 0, 2'b00);
    endtask

    task automatic pix_uv(int mode, int r, int c, output int u, output int vv);
        if (mode == 1) begin
            u = g_cu; vv = g_cv;
        end else if (mode == 2) begin
            u = in_box(1'b1, r, c) ? r - c : 0;
            vv = in_box(1'b1, r, c) ? c - r : 0;
        end else begin
            u = int'($urandom_range(0, 511)) - 256;
            vv = int'($urandom_range(0, 511)) - 256;
        end
    endtask

    // Sparse frame: origin pixel, scattered pixels, active-area edges, then a sweep around the box.
    task automatic frame(int mode, int req_at, bit [1:0] req, int gap);
        int p = 0;
        int u, vv, r, c;
        bit v;
        int br[5] = '{479, 480, 479, 0, 2047};
        int bc[5] = '{639, 639, 640, 640, 4095};
        pix_uv(mode, 0, 0, u, vv);
        drive(1'b1, 0, 0, u, vv, (p == req_at) ? req : 2'b00); p++;
        for (int i = 0; i < 10; i++) begin
            r = int'($urandom_range(300, 2047));
            c = int'($urandom_range(0, 4095));
            pix_uv(mode, r, c, u, vv);
            drive(1'($urandom_range(0, 1)), r, c, u, vv, (p == req_at) ? req : 2'b00); p++;
        end
        for (int i = 0; i < 5; i++) begin
            pix_uv(mode, br[i], bc[i], u, vv);
            drive(1'b1, br[i], bc[i], u, vv, (p == req_at) ? req : 2'b00); p++;
        end
        for (int rr = 234; rr <= 245; rr++) begin
            for (int cc = 314; cc <= 329; cc++) begin
                v = (gap == 0) ? 1'b1 : ($urandom_range(0, gap - 1) != 0);
                pix_uv(mode, rr, cc, u, vv);
                drive(v, rr, cc, u, vv, (p == req_at) ? req : 2'b00); p++;
            end
        end
    endtask

    initial begin : pix_monitor
        pix_exp_t e;
        forever begin
            @(posedge clk);
            if (pq.size() > 0) begin
                e = pq.pop_front();
                @(negedge clk);
                chk("img_in_valid", int'(img_in_valid), int'(e.iv));
                chk("frameCode", int'(frameCode), int'(e.fc));
                chk("busy", int'(busy), int'(e.bsy));
                chk("cal_done", int'(cal_done), int'(e.done));
            end
        end
    end

    initial begin : cal_monitor
        cal_exp_t ce;
        forever begin
            @(negedge clk);
            if (cal_done === 1'b1) begin
                if (cq.size() == 0) begin
                    chk("cal_done_unexpected", 1, 0);
                end else begin
                    ce = cq.pop_front();
                    chk("uTarget1", int'(uTarget1), ce.t[0]);
                    chk("vTarget1", int'(vTarget1), ce.t[1]);
                    chk("uTarget2", int'(uTarget2), ce.t[2]);
                    chk("vTarget2", int'(vTarget2), ce.t[3]);
                end
            end
        end
    end

    task automatic check_reset_outputs(string tag);
        chk({tag, "_img_in_valid"}, int'(img_in_valid), 0);
        chk({tag, "_frameCode"}, int'(frameCode), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_cal_done"}, int'(cal_done), 0);
        chk({tag, "_uTarget1"}, int'(uTarget1), 0);
        chk({tag, "_vTarget1"}, int'(vTarget1), 0);
        chk({tag, "_uTarget2"}, int'(uTarget2), 0);
        chk({tag, "_vTarget2"}, int'(vTarget2), 0);
    endtask

    initial begin : stim
        #1 reset_n = 1'b0;
        #11;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        frame(0, -1, 2'b00, 0);
        frame(0, -1, 2'b00, 0);
        idle(3);

        frame(0, 20, 2'b01, 0);
        g_cu = 100; g_cv = -60;
        frame(1, -1, 2'b00, 0);
        idle(4);
        chk("const_uTarget1", int'(uTarget1), 12);
        chk("const_vTarget1", int'(vTarget1), 56);
        chk("const_uTarget2", int'(uTarget2), 0);

        frame(0, 20, 2'b11, 0);
        frame(0, -1, 2'b00, 0);
        idle(3);
        frame(0, 20, 2'b10, 0);
        g_cu = -256; g_cv = 255;
        frame(1, -1, 2'b00, 0);
        idle(4);
        chk("extreme_uTarget2", int'(uTarget2), 32);
        chk("extreme_vTarget2", int'(vTarget2), 31);

        frame(0, 20, 2'b01, 0);
        frame(2, -1, 2'b00, 0);
        idle(3);

        frame(0, 20, 2'b01, 0);
        g_cu = -17; g_cv = 33;
        frame(1, 200, 2'b10, 0);
        idle(3);

        frame(0, 20, 2'b01, 0);
        frame(0, -1, 2'b00, 4);
        frame(0, -1, 2'b00, 0);
        idle(3);

        // Reset in the middle of accumulation.
        frame(0, 20, 2'b10, 0);
        drive(1'b1, 0, 0, 5, 5, 2'b00);
        for (int rr = 236; rr <= 239; rr++)
            for (int cc = 316; cc <= 323; cc++)
                drive(1'b1, rr, cc, 77, -77, 2'b00);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        pq.delete();
        cq.delete();
        m_phase = 0; m_fc = 0; m_sel = 0;
        m_su.delete(); m_sv.delete();
        m_t = '{0, 0, 0, 0};
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        g_cu = 50; g_cv = 50;
        frame(1, -1, 2'b00, 0);
        idle(4);

        for (int k = 0; k < 6; k++) begin
            g_cu = int'($urandom_range(0, 511)) - 256;
            g_cv = int'($urandom_range(0, 511)) - 256;
            frame(int'($urandom_range(0, 2)), int'($urandom_range(0, 220)),
                  2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0) ? 8 : 0);
        end
        idle(10);
        chk("cal_queue_drained", cq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
